i2c_slave_regfile: RTL

//  Synthesizable I2C slave (responder) with an NREG x 8-bit register file, the target-side counterpart of i2c_master_top.

---
 rtl/i2c_slave_regfile_pkg.sv | 23 ++
 rtl/i2c_slave_regfile_bus_cond.sv | 44 ++++
 rtl/i2c_slave_regfile.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types and constants for the I2C slave register file.
package i2c_slave_regfile_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_e;

  localparam logic        ACK    = 1'b0;
  localparam logic        NACK   = 1'b1;
  localparam int unsigned RW_BIT = 0;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

endpackage

// File: rtl/i2c_slave_regfile_bus_cond.sv
// SCL/SDA synchronizer and bus-condition detector (edges, START, STOP).
module i2c_slave_regfile_bus_cond #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_det_c,
  output logic stop_det_c
);

  logic [SYNC-1:0] scl_sync;
  logic [SYNC-1:0] sda_sync;
  logic            scl_q;
  logic            sda_q;
  logic            scl_s;

  // Idle bus is high, so the chain resets to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC-2:0], scl};
      sda_sync <= {sda_sync[SYNC-2:0], sda};
      scl_q    <= scl_sync[SYNC-1];
      sda_q    <= sda_sync[SYNC-1];
    end
  end

  assign scl_s       = scl_sync[SYNC-1];
  assign sda_s       = sda_sync[SYNC-1];
  assign scl_rise_c  =  scl_s & ~scl_q;
  assign scl_fall_c  = ~scl_s &  scl_q;
  assign start_det_c =  scl_s &  scl_q &  sda_q & ~sda_s;
  assign stop_det_c  =  scl_s &  scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with an NREG x 8 register file: pointer byte, then auto-incrementing data bytes.
module i2c_slave_regfile
  import i2c_slave_regfile_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR = 7'h10,
  parameter int unsigned NREG     = 8,
  parameter int unsigned SYNC     = 2,
  localparam int unsigned PW      = $clog2(NREG)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          scl_pad_i,
  input  logic          sda_pad_i,
  output logic          sda_pad_o,
  output logic          sda_padoen_o,
  input  logic [PW-1:0] reg_idx_i,
  output logic [7:0]    reg_dat_o,
  output logic          wr_stb_o,
  output logic [PW-1:0] wr_idx_o,
  output logic [7:0]    wr_dat_o,
  output logic          busy_o
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_regfile_bus_cond #(.SYNC(SYNC)) u_bus_cond (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_i),
    .scl         (scl_pad_i),
    .sda         (sda_pad_i),
    .sda_s       (sda_s),
    .scl_rise_c  (scl_rise),
    .scl_fall_c  (scl_fall),
    .start_det_c (start_det),
    .stop_det_c  (stop_det)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                rw_q, rw_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                oe_n_q, oe_n_d;
  logic                busy_q, busy_d;
  logic                stb_d;
  logic [PW-1:0]       widx_d;
  logic [BYTE_W-1:0]   wdat_d;
  logic [BYTE_W-1:0]   regs [NREG];
  logic [BYTE_W-1:0]   byte_in;
  logic [BYTE_W-1:0]   rd_byte;

  assign byte_in = {shreg_q[BYTE_W-2:0], sda_s};
  assign rd_byte = regs[ptr_q];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rw_q     <= 1'b0;
      shreg_q  <= '0;
      ptr_q    <= '0;
      oe_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      wr_stb_o <= 1'b0;
      wr_idx_o <= '0;
      wr_dat_o <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rw_q     <= rw_d;
      shreg_q  <= shreg_d;
      ptr_q    <= ptr_d;
      oe_n_q   <= oe_n_d;
      busy_q   <= busy_d;
      wr_stb_o <= stb_d;
      wr_idx_o <= widx_d;
      wr_dat_o <= wdat_d;
    end
  end

  // Commit one cycle after the strobe so a local read during wr_stb_o sees the old value.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wr_stb_o) begin
      regs[wr_idx_o] <= wr_dat_o;
    end
  end

  // done_q marks "8 bits seen" (or "master ACKed" in RDATA_ACK); the next SCL fall acts on it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    rw_d    = rw_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    oe_n_d  = oe_n_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    widx_d  = wr_idx_o;
    wdat_d  = wr_dat_o;

    if (stop_det) begin
      state_d = ST_IDLE;
      oe_n_d  = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      done_d  = 1'b0;
      oe_n_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_IGNORE: oe_n_d = 1'b1;

        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(7)) begin
              done_d = 1'b1;
              if (state_q == ST_PTR) ptr_d = byte_in[PW-1:0];
              if (state_q == ST_WDATA) begin
                stb_d  = 1'b1;
                widx_d = ptr_q;
                wdat_d = byte_in;
                ptr_d  = PW'(ptr_q + 1'b1);
              end
            end
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (shreg_q[BYTE_W-1:1] == I2C_ADDR) begin
                state_d = ST_ADDR_ACK;
                oe_n_d  = ACK;
                busy_d  = 1'b1;
                rw_d    = shreg_q[RW_BIT];
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end else begin
              oe_n_d  = ACK;
              state_d = (state_q == ST_PTR) ? ST_PTR_ACK : ST_WDATA_ACK;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              shreg_d = rd_byte;
              oe_n_d  = rd_byte[BYTE_W-1];
              state_d = ST_RDATA;
            end else begin
              oe_n_d  = 1'b1;
              state_d = ST_PTR;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            oe_n_d  = 1'b1;
            state_d = ST_WDATA;
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(7)) begin
              done_d = 1'b1;
              ptr_d  = PW'(ptr_q + 1'b1);
            end
          end else if (scl_fall) begin
            if (done_q) begin
              done_d  = 1'b0;
              oe_n_d  = 1'b1;
              state_d = ST_RDATA_ACK;
            end else begin
              shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
              oe_n_d  = shreg_q[BYTE_W-2];
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && done_q) begin
            done_d  = 1'b0;
            cnt_d   = '0;
            shreg_d = rd_byte;
            oe_n_d  = rd_byte[BYTE_W-1];
            state_d = ST_RDATA;
          end
        end

        default: begin
          state_d = ST_IDLE;
          oe_n_d  = 1'b1;
        end
      endcase
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oe_n_q;
  assign busy_o       = busy_q;
  assign reg_dat_o    = regs[reg_idx_i];

endmodule
